pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter IMM_WIDTH, default 12, source width for sign extension; SHALL be less than WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  operand handshake; transfer occurs when both are high at a rising edge.
REQ-006 x, y  input  WIDTH  raw operands.
REQ-007 nx, ix, sx, ny, iy, sy  input  1 each  negate, increment and sign-extend controls for x and y.
REQ-008 opcode  input  4  operation select, per REQ-013.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 out  output  WIDTH  registered result.
REQ-011 zero, negative, carry, overflow, illegal  output  1 each  registered flags, aligned with out.

Function
REQ-012 Operand conditioning SHALL apply in this order: sign-extend from bit IMM_WIDTH-1 when sx/sy is set, then bitwise invert when nx/ny is set, then add 1 modulo 2^WIDTH when ix/iy is set.
- The sign of each conditioned operand SHALL be taken after the sign-extend step.
REQ-013 Opcode map, applied to the conditioned operands a and b:
- 0 ADD; 1 SUB (a-b)
- 2 SLL; 3 SRL; 4 SRA
- 5 EQ; 6 NE; 7 LT; 8 GE (signed)
- 9 LTU; 10 GEU
- 11 XOR; 12 OR; 13 AND
- 14 MUL: low WIDTH bits of the product
- 15 illegal
REQ-014 Shifts SHALL use only b[$clog2(WIDTH)-1:0] as the shift amount.
REQ-015 Compares SHALL return 1 or 0, zero-extended to WIDTH.
REQ-016 Opcode 15 SHALL produce out=0 and illegal=1; every other opcode SHALL produce illegal=0.
- The output mux SHALL be fully specified, with no inferred latch.
REQ-017 zero SHALL equal (out==0) for all opcodes, and negative SHALL equal out[WIDTH-1].
REQ-018 carry and overflow SHALL be meaningful for ADD and SUB only, and SHALL be 0 for all other opcodes.
- SUB carry SHALL be 1 when there is no borrow.
REQ-019 The state machine SHALL have two states, IDLE and MUL.
REQ-020 in_ready SHALL be high only when state is IDLE, reset is low, and (!out_valid || out_ready).
REQ-021 A transfer of opcodes 0-13 or 15 at edge k SHALL load out and the flags at edge k, with out_valid high from edge k onward.
- This is a 1-cycle latency with throughput of one operation per cycle.
REQ-022 A transfer of opcode 14 at edge k SHALL do all of the following:
- enter MUL and clear out_valid;
- perform shift-add, one multiplier bit per cycle;
- load the result and set out_valid at edge k+WIDTH;
- return to IDLE on the same edge.
REQ-023 While in MUL, in_ready SHALL be 0 and x, y, opcode and the control inputs SHALL be ignored.
REQ-024 A result SHALL hold stable until out_valid && out_ready at an edge.
- out_valid SHALL then clear unless a new transfer occurs on the same edge, in which case the new result SHALL replace it with no bubble.
REQ-025 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-026 While reset is high at an edge, the block SHALL set all of the following:
- state=IDLE
- out=0 and all flags=0
- out_valid=0
- the MUL counter and accumulator cleared
REQ-027 in_ready SHALL be 0 whenever reset is high.
REQ-028 Reset during MUL SHALL abort the multiply and produce no result.

Structure
REQ-029 Package alu_pkg SHALL hold all of the following:
- enum alu_op_e (4-bit opcode map)
- enum alu_state_e (IDLE, MUL)
- a parametrisable sign-extend function
REQ-030 The single-cycle datapath for conditioning, ADD/SUB, shifts, compares, logic and flags SHALL be one combinational sub-module, alu_core_comb.
REQ-031 The MUL iteration, state machine and output register SHALL reside in pipelined_alu.

Verification (WIDTH=32, IMM_WIDTH=12)
REQ-032 ADD, x=0x7FFFFFFF, y=1 -> out=0x80000000, overflow=1, negative=1, carry=0, out_valid one edge after transfer.
REQ-033 SUB, x=5, y=5 -> out=0, zero=1, carry=1; ADD, x=0x00000FFF, sx=1, y=0 -> out=0xFFFFFFFF.
REQ-034 MUL, x=0xFFFFFFFF, y=3 -> out=0xFFFFFFFD at transfer edge+32; in_ready=0 throughout; a pending in_valid is accepted on the first edge after.
REQ-035 out_ready=0 while SRA x=0x80000000 y=4 and XOR x=0xF0 y=0xFF are offered back-to-back:
- out holds 0xF8000000;
- in_ready stays 0;
- after out_ready rises, 0x0000000F follows in order.
REQ-036 Reset asserted 10 cycles into a MUL -> state IDLE, out_valid=0, and no MUL result ever appears.
REQ-037 opcode=15 -> out=0, illegal=1, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, FSM states and sign-extend helper for pipelined_alu
package alu_pkg;

  // Widest datapath the sign-extend helper handles
  localparam int SEXT_MAX_W = 64;
  localparam int SEXT_IDX_W = $clog2(SEXT_MAX_W);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLL = 4'd2,
    OP_SRL = 4'd3,
    OP_SRA = 4'd4,
    OP_EQ  = 4'd5,
    OP_NE  = 4'd6,
    OP_LT  = 4'd7,
    OP_GE  = 4'd8,
    OP_LTU = 4'd9,
    OP_GEU = 4'd10,
    OP_XOR = 4'd11,
    OP_OR  = 4'd12,
    OP_AND = 4'd13,
    OP_MUL = 4'd14,
    OP_ILL = 4'd15
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Replicate bit sign_bit into every higher bit; callers cast to their own width
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(
    input logic [SEXT_MAX_W-1:0] val,
    input logic [SEXT_IDX_W-1:0] sign_bit
  );
    logic [SEXT_MAX_W-1:0] res;
    res = val;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i > int'(sign_bit)) res[i] = val[sign_bit];
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// rtl/alu_core_comb.sv - operand conditioning and single-cycle ALU datapath with flags
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 12
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             nx,
  input  logic             ix,
  input  logic             sx,
  input  logic             ny,
  input  logic             iy,
  input  logic             sy,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SEXT_IDX_W-1:0] SIGN_BIT = SEXT_IDX_W'(IMM_WIDTH - 1);

  logic [WIDTH-1:0] x_ext;
  logic [WIDTH-1:0] y_ext;
  logic [WIDTH-1:0] x_inv;
  logic [WIDTH-1:0] y_inv;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;

  // Condition operands: sign-extend, then invert, then increment
  always_comb begin
    x_ext = sx ? WIDTH'(sign_extend(SEXT_MAX_W'(x), SIGN_BIT)) : x;
    y_ext = sy ? WIDTH'(sign_extend(SEXT_MAX_W'(y), SIGN_BIT)) : y;
    x_inv = nx ? ~x_ext : x_ext;
    y_inv = ny ? ~y_ext : y_ext;
    a     = ix ? x_inv + WIDTH'(1) : x_inv;
    b     = iy ? y_inv + WIDTH'(1) : y_inv;
  end

  // Opcode mux; MUL yields 0 here because the iterative unit in the top owns it
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    shamt    = b[SHW-1:0];
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        result   = add_full[WIDTH-1:0];
        carry    = add_full[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = sub_full[WIDTH-1:0];
        carry    = sub_full[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      OP_EQ:   result = WIDTH'(a == b);
      OP_NE:   result = WIDTH'(a != b);
      OP_LT:   result = WIDTH'($signed(a) < $signed(b));
      OP_GE:   result = WIDTH'($signed(a) >= $signed(b));
      OP_LTU:  result = WIDTH'(a < b);
      OP_GEU:  result = WIDTH'(a >= b);
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_MUL:  result = '0;
      OP_ILL:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    zero     = (result == '0);
    negative = result[WIDTH-1];
  end

endmodule

// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - handshaked ALU with registered result and shift-add multiplier
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             nx,
  input  logic             ix,
  input  logic             sx,
  input  logic             ny,
  input  logic             iy,
  input  logic             sy,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_negative;
  logic             core_carry;
  logic             core_overflow;
  logic             core_illegal;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire;
  logic [WIDTH-1:0] product;

  alu_core_comb #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_core (
    .x        (x),
    .y        (y),
    .nx       (nx),
    .ix       (ix),
    .sx       (sx),
    .ny       (ny),
    .iy       (iy),
    .sy       (sy),
    .opcode   (opcode),
    .a        (core_a),
    .b        (core_b),
    .result   (core_result),
    .zero     (core_zero),
    .negative (core_negative),
    .carry    (core_carry),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  // Accept only when idle, out of reset, and the output slot is free or draining
  assign in_ready = (state_q == ST_IDLE) && !reset && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Next-state: output register handshake, single-cycle loads and multiply iteration
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product     = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (in_fire) begin
          if (alu_op_e'(opcode) == OP_MUL) begin
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
            mcand_d     = core_a;
            mplier_d    = core_b;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            out_d       = core_result;
            zero_d      = core_zero;
            negative_d  = core_negative;
            carry_d     = core_carry;
            overflow_d  = core_overflow;
            illegal_d   = core_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = product;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          out_d       = product;
          zero_d      = (product == '0);
          negative_d  = product[WIDTH-1];
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset also aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - scoreboard bench for pipelined_alu with a reference model
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        nx = 1'b0, ix = 1'b0, sx = 1'b0, ny = 1'b0, iy = 1'b0, sy = 1'b0;
  logic [3:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        zero, negative, carry, overflow, illegal;

  pipelined_alu #(.WIDTH(32), .IMM_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .nx(nx), .ix(ix), .sx(sx), .ny(ny), .iy(iy), .sy(sy),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {out, zero, negative, carry, overflow, illegal}
  typedef logic [36:0] res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [31:0] cond(input logic [31:0] v, input logic s, input logic n, input logic i);
    logic [31:0] r;
    r = v;
    if (s) r = r[11] ? (r | 32'hFFFF_F000) : (r & 32'h0000_0FFF);
    if (n) r = ~r;
    if (i) r = r + 32'd1;
    return r;
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0]     r;
    logic            c, v, il;
    longint          sa, sbv, full;
    longint unsigned ua, ub, u;
    int              sh;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    sa = $signed(a); sbv = $signed(b);
    ua = a; ub = b;
    sh = int'(b % 32);
    case (op)
      4'd0: begin
        u = ua + ub; r = u[31:0]; c = u[32];
        full = sa + sbv; v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        full = sa - sbv; v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      4'd2:  r = a << sh;
      4'd3:  r = a >> sh;
      4'd4:  r = $signed(a) >>> sh;
      4'd5:  r = {31'd0, a == b};
      4'd6:  r = {31'd0, a != b};
      4'd7:  r = {31'd0, sa < sbv};
      4'd8:  r = {31'd0, sa >= sbv};
      4'd9:  r = {31'd0, ua < ub};
      4'd10: r = {31'd0, ua >= ub};
      4'd11: r = a ^ b;
      4'd12: r = a | b;
      4'd13: r = a & b;
      4'd14: begin u = ua * ub; r = u[31:0]; end
      default: il = 1'b1;
    endcase
    return {r, r == 32'd0, r[31], c, v, il};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compare every result consumed by the downstream side
  initial begin
    res_t got, want;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && out_valid && out_ready) begin
        got = {out, zero, negative, carry, overflow, illegal};
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got=%h want=none", got);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL result: got=%h want=%h", got, want);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [3:0] op, input logic [31:0] xv, input logic [31:0] yv,
                      input logic [5:0] ctl, output int fire_cyc);
    bit done;
    int waited;
    done = 0; waited = 0; fire_cyc = -1;
    x = xv; y = yv; opcode = op;
    {sx, nx, ix, sy, ny, iy} = ctl;
    in_valid = 1'b1;
    while (!done) begin
      #4;
      if (in_ready) begin
        sb.push_back(model(op, cond(xv, ctl[5], ctl[4], ctl[3]), cond(yv, ctl[2], ctl[1], ctl[0])));
        fire_cyc = cyc + 1;
        done = 1;
      end
      @(negedge clk);
      if (!done) begin
        waited++;
        if (waited > 300) begin
          n_cmp++; n_bad++;
          $display("FAIL send_timeout: got=no_accept want=accept op=%0d", op);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 600) begin
      n_bad++;
      $display("FAIL drain_timeout: got=%0d pending want=0", sb.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, f1;
    logic [3:0] op;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_flags", {27'd0, out, zero, negative, carry, overflow, illegal}, 64'd0);
    reset = 1'b0;

    // Single-cycle results with fixed expectations
    send(4'd0, 32'h7FFF_FFFF, 32'd1, 6'b000000, f0);
    chk("add_ovf_valid", {63'd0, out_valid}, 64'd1);
    chk("add_ovf", {27'd0, out, zero, negative, carry, overflow, illegal}, {27'd0, 32'h8000_0000, 5'b01010});
    send(4'd1, 32'd5, 32'd5, 6'b000000, f0);
    chk("sub_eq", {27'd0, out, zero, negative, carry, overflow, illegal}, {27'd0, 32'h0, 5'b10100});
    send(4'd0, 32'h0000_0FFF, 32'd0, 6'b100000, f0);
    chk("add_sext", {27'd0, out, zero, negative, carry, overflow, illegal}, {27'd0, 32'hFFFF_FFFF, 5'b01000});
    send(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 6'b000000, f0);
    chk("illegal", {27'd0, out, zero, negative, carry, overflow, illegal}, {27'd0, 32'h0, 5'b10001});
    send(4'd1, 32'd3, 32'd5, 6'b000000, f0);
    chk("sub_borrow", {27'd0, out, zero, negative, carry, overflow, illegal}, {27'd0, 32'hFFFF_FFFE, 5'b01000});
    wait_drain();

    // Multiply latency, stall of in_ready, and pending request accepted right after
    send(4'd14, 32'hFFFF_FFFF, 32'd3, 6'b000000, f0);
    fork
      send(4'd0, 32'd1, 32'd2, 6'b000000, f1);
      begin
        for (int i = 0; i < 31; i++) begin
          #4;
          chk("mul_in_ready", {63'd0, in_ready}, 64'd0);
          chk("mul_out_valid", {63'd0, out_valid}, 64'd0);
          #6;
        end
        #10;
        chk("mul_result", {31'd0, out_valid, out}, {31'd0, 1'b1, 32'hFFFF_FFFD});
      end
    join
    chk("mul_next_accept", 64'(f1 - f0), 64'd33);
    wait_drain();

    // Back-pressure: result holds and in_ready stays low, order kept afterwards
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    send(4'd4, 32'h8000_0000, 32'd4, 6'b000000, f0);
    fork
      send(4'd11, 32'h0000_00F0, 32'h0000_00FF, 6'b000000, f1);
      begin
        for (int i = 0; i < 5; i++) begin
          #4;
          chk("hold_out", {31'd0, out_valid, out}, {31'd0, 1'b1, 32'hF800_0000});
          chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
          #6;
        end
        rdy_mode = 0;
      end
    join
    wait_drain();

    // Reset ten cycles into a multiply must discard it
    send(4'd14, 32'h0001_2345, 32'h0000_0777, 6'b000000, f0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #4;
      chk("abort_no_result", {63'd0, out_valid}, 64'd0);
      #6;
    end
    chk("abort_idle", {63'd0, in_ready}, 64'd1);

    // Randomized traffic with random downstream stalls
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      send(op,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           6'($urandom), f0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
